quad_encoder_counter: RTL

Quadrature encoder front-end for the motor-control FPGA fabric: synchronises and glitch-filters one A/B encoder pair, decodes it in x4 mode into a signed 32-bit position, and measures speed as the count delta over a fixed time window. Two instances, one per wheel, drive the four 32-bit input PIOs of the HPS system (pio_0..pio_3), so the HPS reads position and speed by plain PIO reads.

---
 rtl/quad_enc_pkg.sv | 33 +++
 rtl/enc_input_filter.sv | 70 +++++++
 rtl/quad_encoder_counter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg
// Shared widths, step encoding and the 2-bit Gray transition decoder used by
// quad_encoder_counter. The optional error logic in the top level is enabled
// with the macro QUAD_ENC_ERR_EN; nothing in this package depends on it.
package quad_enc_pkg;

  localparam int CNT_W = 32;
  localparam int ERR_W = 16;

  typedef logic [1:0] step_t;

  localparam step_t STEP_NONE = 2'b00;
  localparam step_t STEP_UP   = 2'b01;
  localparam step_t STEP_DN   = 2'b10;
  localparam step_t STEP_ILL  = 2'b11;

  // Decode one transition of the {A,B} pair.
  // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] nxt;
    case (prev)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    if (cur == prev)                return STEP_NONE;
    else if ((cur ^ prev) == 2'b11) return STEP_ILL;
    else if (cur == nxt)            return STEP_UP;
    else                            return STEP_DN;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// enc_input_filter
// Synchroniser plus glitch filter for one asynchronous encoder channel.
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_pin    raw asynchronous input
//   o_level  accepted (filtered) level
//   o_valid  high once a first level has been accepted after reset
// After reset the accepted level is unknown: o_valid stays low until the
// synchronised value has been stable for SYNC_STAGES+FILTER_LEN samples, which
// also flushes the reset value out of the synchroniser. From then on a new
// level is accepted after FILTER_LEN consecutive differing samples.
module enc_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_valid
);

  localparam int PRIME_LEN = SYNC_STAGES + FILTER_LEN;
  localparam int CW        = $clog2(PRIME_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_valid;
  logic [CW-1:0]          r_cnt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      if (!r_valid) begin
        // Priming: track the current run of identical samples.
        if (w_sync != r_level) begin
          r_level <= w_sync;
          r_cnt   <= CW'(1);
        end else if (r_cnt == CW'(PRIME_LEN - 1)) begin
          r_valid <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (w_sync != r_level) begin
        if (r_cnt == CW'(FILTER_LEN - 1)) begin
          r_level <= w_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        // Any sample matching the accepted level restarts the run.
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_valid = r_valid;

endmodule

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter
// x4 quadrature decoder with position counter and windowed speed measurement.
//   clk          system clock
//   reset        asynchronous active-high reset
//   enc_a/enc_b  asynchronous encoder channels
//   dir_invert   static; negates the count direction
//   clear        synchronous pulse; zeroes position, speed, window and errors
//   position     signed 32-bit step count (wraps)
//   speed        steps counted in the last completed window
//   speed_valid  one-cycle pulse when speed updates
//   err          sticky illegal-transition flag
//   err_count    saturating illegal-transition counter
// Build option: define QUAD_ENC_ERR_EN to enable err/err_count; otherwise both
// are tied to 0 (illegal transitions still produce no step).
module quad_encoder_counter
  import quad_enc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int SPEED_WINDOW = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             dir_invert,
  input  logic             clear,
  output logic [CNT_W-1:0] position,
  output logic [CNT_W-1:0] speed,
  output logic             speed_valid,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int WIN_W = $clog2(SPEED_WINDOW);

  logic             w_a_lvl, w_a_vld, w_b_lvl, w_b_vld;
  logic [1:0]       w_cur;
  step_t            w_step_raw;
  step_t            w_step;

  logic [1:0]       r_prev;
  logic             r_primed;
  logic [CNT_W-1:0] r_position;
  logic [CNT_W-1:0] r_snapshot;
  logic [CNT_W-1:0] r_speed;
  logic             r_speed_valid;
  logic [WIN_W-1:0] r_win;

  enc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .i_clk(clk), .i_rst(reset), .i_pin(enc_a), .o_level(w_a_lvl), .o_valid(w_a_vld)
  );

  enc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .i_clk(clk), .i_rst(reset), .i_pin(enc_b), .o_level(w_b_lvl), .o_valid(w_b_vld)
  );

  assign w_cur      = {w_a_lvl, w_b_lvl};
  assign w_step_raw = r_primed ? gray_step(r_prev, w_cur) : STEP_NONE;

  always_comb begin
    w_step = w_step_raw;
    if (dir_invert && (w_step_raw == STEP_UP)) w_step = STEP_DN;
    if (dir_invert && (w_step_raw == STEP_DN)) w_step = STEP_UP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev        <= 2'b00;
      r_primed      <= 1'b0;
      r_position    <= '0;
      r_snapshot    <= '0;
      r_speed       <= '0;
      r_speed_valid <= 1'b0;
      r_win         <= '0;
    end else begin
      // The first accepted pair only seeds the previous-state register.
      if (!r_primed) begin
        if (w_a_vld && w_b_vld) begin
          r_prev   <= w_cur;
          r_primed <= 1'b1;
        end
      end else begin
        r_prev <= w_cur;
      end

      if (clear) begin
        r_position    <= '0;
        r_snapshot    <= '0;
        r_speed       <= '0;
        r_speed_valid <= 1'b0;
        r_win         <= '0;
      end else begin
        if (w_step == STEP_UP)      r_position <= r_position + CNT_W'(1);
        else if (w_step == STEP_DN) r_position <= r_position - CNT_W'(1);

        // Snapshot uses the registered position, so a step on this same edge
        // belongs to the next window.
        if (r_win == WIN_W'(SPEED_WINDOW - 1)) begin
          r_win         <= '0;
          r_speed       <= r_position - r_snapshot;
          r_snapshot    <= r_position;
          r_speed_valid <= 1'b1;
        end else begin
          r_win         <= r_win + WIN_W'(1);
          r_speed_valid <= 1'b0;
        end
      end
    end
  end

  assign position    = r_position;
  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;

`ifdef QUAD_ENC_ERR_EN
  logic             r_err;
  logic [ERR_W-1:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else if (clear) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else if (w_step_raw == STEP_ILL) begin
      r_err <= 1'b1;
      if (r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign err       = r_err;
  assign err_count = r_err_count;
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule
